// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
`timescale 1ns/1ps
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SKID       = 1,
  parameter int unsigned FLUSH_ZERO = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Encoding chosen so bit 0 is the main valid and bit 1 is the skid valid.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_d_q, m_d_d;
  logic [DATA_W-1:0] s_d_q, s_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic m_v, s_v, accept, consume, stall;

  assign m_v = state_q[0];
  assign s_v = state_q[1];

  // With the skid buffer, in_ready depends only on the skid-valid flop.
  assign in_ready_o  = (SKID != 0) ? ~s_v : (~m_v | out_ready_i);
  assign out_valid_o = m_v;
  assign out_data_o  = m_d_q;
  assign occupancy_o = {s_v, m_v & ~s_v};
  assign stall_cnt_o = cnt_q;

  assign accept  = in_valid_i & in_ready_o & ~flush_i;
  assign consume = m_v & out_ready_i;
  assign stall   = m_v & ~out_ready_i & ~flush_i;

  always_comb begin
    state_d = state_q;
    m_d_d   = m_d_q;
    s_d_d   = s_d_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          m_d_d   = in_data_i;
        end
      end
      StOne: begin
        if (accept && consume) begin
          m_d_d = in_data_i;
        end else if (accept) begin
          // Only reachable with the skid buffer; without it accept implies consume.
          state_d = StFull;
          s_d_d   = in_data_i;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (consume) begin
          state_d = StOne;
          m_d_d   = s_d_q;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (flush_i) begin
      state_d = StEmpty;
      if (FLUSH_ZERO != 0) begin
        m_d_d = '0;
        s_d_d = '0;
      end
    end

    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      if (FLUSH_ZERO != 0) begin
        m_d_q <= '0;
        s_d_q <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_d_q   <= m_d_d;
      s_d_q   <= s_d_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: skid mode, non-skid mode and a narrow
// stall counter instance, each with hand-computed expectations.
`timescale 1ns/1ps
module tb_pipe_stage_skid;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  // Instance a: SKID=1, 32-bit, CNT_W=16
  logic        a_flush, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_id, a_od;
  logic [1:0]  a_occ;
  logic [15:0] a_sc;

  // Instance b: SKID=0, 32-bit
  logic        b_flush, b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_occ;
  logic [15:0] b_sc;

  // Instance c: SKID=1, 8-bit, CNT_W=4
  logic        c_flush, c_iv, c_ir, c_ov, c_or;
  logic [7:0]  c_id, c_od;
  logic [1:0]  c_occ;
  logic [3:0]  c_sc;

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .FLUSH_ZERO(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .in_valid_i(a_iv), .in_data_i(a_id),
    .in_ready_o(a_ir), .out_valid_o(a_ov), .out_data_o(a_od), .out_ready_i(a_or),
    .occupancy_o(a_occ), .stall_cnt_o(a_sc)
  );

  pipe_stage_skid #(.DATA_W(32), .SKID(0), .FLUSH_ZERO(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .in_valid_i(b_iv), .in_data_i(b_id),
    .in_ready_o(b_ir), .out_valid_o(b_ov), .out_data_o(b_od), .out_ready_i(b_or),
    .occupancy_o(b_occ), .stall_cnt_o(b_sc)
  );

  pipe_stage_skid #(.DATA_W(8), .SKID(1), .FLUSH_ZERO(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush_i(c_flush), .in_valid_i(c_iv), .in_data_i(c_id),
    .in_ready_o(c_ir), .out_valid_o(c_ov), .out_data_o(c_od), .out_ready_i(c_or),
    .occupancy_o(c_occ), .stall_cnt_o(c_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a_flush = 0; a_iv = 0; a_id = '0; a_or = 0;
    b_flush = 0; b_iv = 0; b_id = '0; b_or = 0;
    c_flush = 0; c_iv = 0; c_id = '0; c_or = 0;
    step();
    step();
    chk("rst_a_ov", a_ov, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_sc", a_sc, 0);
    chk("rst_a_od", a_od, 0);
    rst = 1'b0;
    step();
    chk("post_rst_a_ir", a_ir, 1);
    chk("post_rst_b_ir", b_ir, 1);
    chk("post_rst_b_ov", b_ov, 0);

    // Streaming through the skid instance
    a_or = 1; a_iv = 1; a_id = 32'd1;
    step();
    chk("stream_od_1", a_od, 1);
    chk("stream_ov_1", a_ov, 1);
    for (int i = 2; i <= 4; i++) begin
      a_id = i;
      step();
      chk("stream_od", a_od, i);
      chk("stream_occ", a_occ, 1);
      chk("stream_ir", a_ir, 1);
    end
    a_iv = 0;
    step();
    chk("stream_drain_ov", a_ov, 0);
    chk("stream_sc", a_sc, 0);

    // Back-pressure fills the skid entry
    a_or = 0; a_iv = 1; a_id = 32'hA;
    step();
    chk("bp_ov", a_ov, 1);
    chk("bp_od_a0", a_od, 32'hA);
    a_id = 32'hB;
    step();
    chk("bp_occ_full", a_occ, 2);
    chk("bp_ir_full", a_ir, 0);
    chk("bp_od_a1", a_od, 32'hA);
    chk("bp_sc1", a_sc, 1);
    a_iv = 0;
    step();
    step();
    chk("bp_od_hold", a_od, 32'hA);
    chk("bp_sc3", a_sc, 3);
    a_or = 1;
    step();
    chk("bp_od_b", a_od, 32'hB);
    chk("bp_occ_one", a_occ, 1);
    chk("bp_ir_one", a_ir, 1);
    step();
    chk("bp_drain_ov", a_ov, 0);
    chk("bp_drain_occ", a_occ, 0);
    chk("bp_sc_keep", a_sc, 3);

    // Flush a full buffer with a simultaneous input
    a_or = 0; a_iv = 1; a_id = 32'h11;
    step();
    a_id = 32'h22;
    step();
    chk("fl_occ_pre", a_occ, 2);
    chk("fl_sc_pre", a_sc, 4);
    a_flush = 1; a_id = 32'hC;
    step();
    chk("fl_ov", a_ov, 0);
    chk("fl_occ", a_occ, 0);
    chk("fl_od_zero", a_od, 0);
    chk("fl_sc_kept", a_sc, 4);
    chk("fl_ir", a_ir, 1);
    a_flush = 0; a_iv = 0;
    step();
    chk("fl_no_c_ov", a_ov, 0);
    chk("fl_no_c_od", a_od, 0);

    // Non-skid instance: combinational in_ready
    b_iv = 1; b_id = 32'h7; b_or = 0;
    step();
    chk("ns_ov", b_ov, 1);
    chk("ns_od7", b_od, 32'h7);
    chk("ns_ir_blocked", b_ir, 0);
    b_or = 1; b_id = 32'h5;
    #1;
    chk("ns_ir_comb", b_ir, 1);
    step();
    chk("ns_od5", b_od, 32'h5);
    chk("ns_ov5", b_ov, 1);
    chk("ns_occ", b_occ, 1);
    chk("ns_sc", b_sc, 0);
    b_iv = 0;
    step();
    chk("ns_drain", b_ov, 0);
    b_iv = 1; b_id = 32'h9; b_or = 0;
    step();
    chk("ns_od9", b_od, 32'h9);
    b_or = 1; b_flush = 1; b_id = 32'hA;
    step();
    chk("ns_fl_ov", b_ov, 0);
    chk("ns_fl_od", b_od, 0);
    b_flush = 0; b_iv = 0; b_or = 0;

    // Stall counter saturation on the 4-bit instance
    c_iv = 1; c_id = 8'h3C; c_or = 0;
    step();
    chk("sat_occ", c_occ, 1);
    chk("sat_ir", c_ir, 1);
    c_iv = 0;
    repeat (14) step();
    chk("sat_sc14", c_sc, 14);
    repeat (6) step();
    chk("sat_sc15", c_sc, 15);
    chk("sat_ov", c_ov, 1);
    chk("sat_od", c_od, 8'h3C);

    // Reset and flush together while an accept is attempted
    a_iv = 1; a_id = 32'h33; a_or = 0;
    step();
    chk("rf_pre_od", a_od, 32'h33);
    rst = 1; a_flush = 1; a_id = 32'hDD;
    step();
    chk("rf_a_ov", a_ov, 0);
    chk("rf_a_occ", a_occ, 0);
    chk("rf_a_od", a_od, 0);
    chk("rf_a_sc", a_sc, 0);
    chk("rf_c_sc", c_sc, 0);
    chk("rf_c_ov", c_ov, 0);
    rst = 0; a_flush = 0; a_iv = 0;
    step();
    chk("rf_a_ir", a_ir, 1);
    chk("rf_a_ov_after", a_ov, 0);
    chk("rf_a_od_after", a_od, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register that replaces fixed stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries an opaque payload with a valid/ready handshake, so back-pressure (cache miss, multi-cycle ALU) stalls the stage without dropping data.
- Optional two-entry skid buffer registers in_ready and breaks the combinational ready path.
- Adds a synchronous flush for branch mispredict and a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 32: payload width in bits (control word plus operands, concatenated by the instantiator).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- FLUSH_ZERO, 1: 1 = payload registers cleared to 0 on rst/flush; 0 = only valid bits cleared.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries (branch mispredict).
- in_valid  in  1  upstream has a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage accepts a payload this cycle.
- out_valid  out  1  stage presents a payload.
- out_data  out  DATA_W  presented payload.
- out_ready  in  1  downstream consumes the payload this cycle.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake rules:
  - Accept = in_valid & in_ready & !flush.
  - Consume = out_valid & out_ready.
  - in_data is sampled on the accept edge.
  - out_valid/out_data are register outputs, and out_data is stable while out_valid=1 and out_ready=0.
- Reset:
  - out_valid=0, occupancy=0, stall_cnt=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Payload registers are 0 if FLUSH_ZERO=1, otherwise don't-care.
- SKID=1 registers: main (m_v, m_d) and skid (s_v, s_d).
  - out_valid = m_v, out_data = m_d.
  - in_ready = !s_v, driven directly from a flop with no combinational path from out_ready.
- SKID=1 states:
  - EMPTY (m_v=0, s_v=0):
    - accept -> ONE; payload goes to main.
  - ONE (m_v=1, s_v=0):
    - accept & consume -> ONE; main takes the new payload.
    - accept & !consume -> FULL; payload goes to skid.
    - !accept & consume -> EMPTY.
    - otherwise hold.
  - FULL (m_v=1, s_v=1):
    - consume -> ONE; main <= skid, s_v <= 0.
    - no accept is possible because in_ready=0.
    - otherwise hold.
- SKID=0:
  - in_ready = !m_v | out_ready (combinational).
  - accept loads main; consume without accept clears m_v.
  - Latency is one cycle in both modes: a payload accepted at edge N is visible on out_data after edge N.
- Flush:
  - At the edge, m_v and s_v go to 0 (state EMPTY).
  - Any simultaneous in_valid is discarded, not held.
  - A simultaneous consume still counts as consumed downstream; the payload is not replayed.
  - Payload is zeroed if FLUSH_ZERO=1.
  - stall_cnt is NOT cleared by flush.
- Precedence: rst > flush > normal operation.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- occupancy = m_v + s_v.
- Rst asserted mid-transfer: all held payloads are dropped, with no partial outputs.
- Ordering: payloads leave in acceptance order. Skid data never overtakes main data.

Test Plan:
- Streaming with out_ready=1, in_valid=1, SKID=1, in_data = 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later; in_ready stays 1; occupancy=1; stall_cnt=0.
- Back-pressure, SKID=1: accept 0xA, then 0xB with out_ready=0 -> occupancy=2, in_ready=0 next cycle, out_data holds 0xA; raise out_ready -> outputs 0xA then 0xB; stall_cnt=number of stalled cycles (e.g. 3).
- Flush with FULL buffer plus a simultaneous in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, out_data=0 (FLUSH_ZERO=1); 0xC never appears; stall_cnt unchanged.
- SKID=0, out_valid=1, out_ready=0 -> in_ready=0 the same cycle; out_ready=1 with in_valid=1, data 0x5 -> next cycle out_data=0x5, out_valid=1.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15; rst -> stall_cnt=0, out_valid=0.
- rst and flush asserted together while accept is attempted -> reset values, in_ready=1 next cycle, no payload retained.
